trap_seq: RTL and testbench
===========================

Name: trap_seq

Overview:
Trap-entry/exit sequencer for the pipelined RV32I core, placed between the WB-boundary commit point, the CSR file and the IF-stage PC mux. It arbitrates between synchronous exceptions, pending machine interrupts and MRET. It performs the required CSR updates as a serial write sequence over the single CSR write port. It then flushes the pipeline and redirects fetch.

Parameters:
RESET_MTVEC, 32'h0000_0000, redirect target used if mtvec reads zero
XLEN, 32, data/address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
commit_valid  in  1  an instruction is at the commit point this cycle
commit_pc  in  XLEN  PC of the committing instruction
exc_valid  in  1  committing instruction raised an exception
exc_code  in  4  exception code (0..15)
exc_tval  in  XLEN  trap value for the exception
mret_valid  in  1  committing instruction is MRET
irq_meip, irq_msip, irq_mtip  in  1 each  raw interrupt lines
mstatus_q  in  XLEN  current mstatus
mie_q  in  XLEN  current mie
mtvec_q  in  XLEN  current mtvec
mepc_q  in  XLEN  current mepc
csr_we  out  1  CSR write strobe
csr_waddr  out  12  CSR address
csr_wdata  out  XLEN  CSR write data
flush  out  1  kill all younger pipeline stages
stall  out  1  freeze IF/ID while the sequence runs
redirect_valid  out  1  one-cycle PC redirect
redirect_pc  out  XLEN  new fetch PC
busy  out  1  FSM not IDLE

Behaviour:
- Reset: state=IDLE. All outputs 0 (csr_waddr=0, csr_wdata=0, redirect_pc=0).
- Interrupt pending: irq_x & mie_q[bit] & mstatus_q.MIE[3]. Bits: MEI=11, MSI=3, MTI=7. Fixed priority MEI > MSI > MTI.
- Acceptance happens only in IDLE with commit_valid=1. Priority: exc_valid > mret_valid > interrupt.
- Exception and interrupt with exc_valid: the interrupt stays pending and is re-evaluated after return.
- Exception: mepc=commit_pc; mcause={0,exc_code}; mtval=exc_tval.
- Interrupt: mepc=commit_pc, so the committing instruction is squashed and re-executed. mcause={1,27'b0,code}; mtval=0.
- On accept cycle (C0): flush=1 for one cycle. The captured values are latched into internal regs. stall=1 and busy=1 from C0 until return to IDLE inclusive of the redirect cycle.
- Trap FSM, one state per cycle:
  - W_MEPC (C1, 0x341)
  - W_MCAUSE (C2, 0x342)
  - W_MTVAL (C3, 0x343)
  - W_MSTATUS (C4, 0x300): MPIE<=MIE, MIE<=0, MPP[12:11]<=2'b11, other bits unchanged.
  - REDIRECT (C5): redirect_valid=1, csr_we=0.
  - Then IDLE.
- Trap target:
  - mtvec_q==0 -> RESET_MTVEC.
  - mtvec_q[1:0]==01 and interrupt -> {mtvec_q[31:2],2'b00} + 4*code.
  - Otherwise -> {mtvec_q[31:2],2'b00}.
- Target and mstatus are computed from CSR values sampled in the state that uses them; mepc/mcause are not re-read.
- MRET FSM:
  - C0: flush.
  - M_MSTATUS (C1, 0x300): MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - REDIRECT (C2): redirect_pc=mepc_q & ~32'h3.
  - Then IDLE.
- csr_we is high exactly in the W_*/M_* states; it is never asserted in IDLE or REDIRECT.
- Inputs are ignored while busy. No event is queued; the pipeline is stalled, so none arrive legitimately.
- Interrupt lines are level-sensitive; pending is recomputed every IDLE cycle.
- Back-to-back: the cycle after REDIRECT is IDLE and may accept a new event.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. Partial CSR writes already made are not undone.

Decomposition:
- Shared package trap_pkg holds:
  - CSR addresses (CSR_MSTATUS/MEPC/MCAUSE/MTVAL)
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11)
  - interrupt codes (3/7/11)
  - FSM state encoding
- Sub-module irq_prio: combinational pending/priority encoder producing irq_take and irq_code.

Test Plan:
1. Illegal instruction: exc_valid, code=2, commit_pc=0x100, tval=0xDEAD, mtvec=0x200, mstatus=0x8 -> writes 0x341=0x100, 0x342=0x2, 0x343=0xDEAD, 0x300=0x1880 on C1..C4; redirect_pc=0x200 at C5.
2. Timer IRQ, vectored: irq_mtip=1, mie=0x80, mstatus=0x8, mtvec=0x201, pc=0x44 -> mcause=0x80000007, mtval=0, redirect_pc=0x21C.
3. MRET: mstatus=0x1880, mepc=0x106 -> 0x300 written 0x1888 at C1; redirect_pc=0x104 at C2; busy for 3 cycles.
4. Simultaneous MEI+MTI with exc_valid code=11 -> exception taken (mcause=0xB). Then with MIE=0 no interrupt is taken. With MIE=1 and no exception, mcause=0x8000000B (MEI beats MTI).
5. Interrupt masked: irq_msip=1, mie=0x8, mstatus.MIE=0 -> no flush or csr_we over 10 cycles. Set MIE=1 -> accept on the next commit_valid.
6. Assert rst at C2 of a trap -> all outputs 0 asynchronously, state IDLE. A new exception after release runs the full C1..C5 sequence.

Source files
------------

// File: rtl/trap_seq_pkg.sv
// Shared definitions for the trap-entry/exit sequencer.
// Contents:
//   - CSR addresses written by the sequencer.
//   - mstatus and mie bit positions.
//   - Machine interrupt cause codes.
//   - FSM state encoding.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie enable bits sit at the same index as the matching cause code
  localparam int MIE_MSI = 3;
  localparam int MIE_MTI = 7;
  localparam int MIE_MEI = 11;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MTVAL,
    S_W_MSTATUS,
    S_M_MSTATUS,
    S_REDIRECT
  } state_t;

endpackage

// File: rtl/trap_seq_if.sv
// Bus bundle between the commit point / CSR file / fetch and the trap
// sequencer.
//   - master: the pipeline side. It drives the commit, exception and
//     interrupt lines and the CSR read values, and receives the CSR
//     write, flush, stall and redirect signals.
//   - slave: the sequencer (trap_seq).
interface trap_seq_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            exc_valid;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tval;
  logic            mret_valid;
  logic            irq_meip;
  logic            irq_msip;
  logic            irq_mtip;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            flush;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport master (
    output commit_valid, commit_pc, exc_valid, exc_code, exc_tval,
           mret_valid, irq_meip, irq_msip, irq_mtip,
           mstatus_q, mie_q, mtvec_q, mepc_q,
    input  csr_we, csr_waddr, csr_wdata, flush, stall,
           redirect_valid, redirect_pc, busy
  );

  modport slave (
    input  commit_valid, commit_pc, exc_valid, exc_code, exc_tval,
           mret_valid, irq_meip, irq_msip, irq_mtip,
           mstatus_q, mie_q, mtvec_q, mepc_q,
    output csr_we, csr_waddr, csr_wdata, flush, stall,
           redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/trap_seq_irq_prio.sv
// Combinational machine-interrupt pending/priority encoder.
// Inputs:
//   - Raw interrupt lines.
//   - The matching mie enable bits.
//   - The global mstatus.MIE bit.
// Outputs:
//   - irq_take: some interrupt is pending and enabled.
//   - irq_code: cause code of the winner.
// Priority order: MEI > MSI > MTI.
module irq_prio
  import trap_pkg::*;
(
  input  logic       irq_meip,
  input  logic       irq_msip,
  input  logic       irq_mtip,
  input  logic       mstatus_mie,
  input  logic       mie_meie,
  input  logic       mie_msie,
  input  logic       mie_mtie,
  output logic       irq_take,
  output logic [3:0] irq_code
);

  always_comb begin
    irq_take = 1'b0;
    irq_code = '0;
    if (mstatus_mie) begin
      if (irq_meip && mie_meie) begin
        irq_take = 1'b1;
        irq_code = IRQ_CODE_MEI;
      end else if (irq_msip && mie_msie) begin
        irq_take = 1'b1;
        irq_code = IRQ_CODE_MSI;
      end else if (irq_mtip && mie_mtie) begin
        irq_take = 1'b1;
        irq_code = IRQ_CODE_MTI;
      end
    end
  end

endmodule

// File: rtl/trap_seq.sv
// Trap-entry/exit sequencer for the RV32I pipeline.
// In IDLE it accepts one event per committing instruction. Priority is
// exception > MRET > pending interrupt.
// Trap entry:
//   - C0: flush.
//   - C1..C4: write mepc, mcause, mtval, mstatus over the single CSR
//     write port.
//   - C5: redirect fetch to the trap vector.
// MRET:
//   - C0: flush.
//   - C1: write mstatus.
//   - C2: redirect fetch to mepc.
// Ports:
//   - clk, rst: clock and asynchronous active-high reset.
//   - bus (slave modport): commit/exception/MRET/interrupt inputs, CSR read
//     values, CSR write port, flush, stall, redirect and busy outputs.
module trap_seq
  import trap_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
  input  logic       clk,
  input  logic       rst,
  trap_seq_if.slave  bus
);

  state_t          state, state_nxt;
  logic            is_mret_r, is_irq_r;
  logic [3:0]      code_r;
  logic [XLEN-1:0] epc_r, tval_r;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic            accept;
  logic            unused_mie;

  assign unused_mie = ^{bus.mie_q[XLEN-1:12], bus.mie_q[10:8],
                        bus.mie_q[6:4], bus.mie_q[2:0]};

  irq_prio u_irq_prio (
    .irq_meip    (bus.irq_meip),
    .irq_msip    (bus.irq_msip),
    .irq_mtip    (bus.irq_mtip),
    .mstatus_mie (bus.mstatus_q[MSTATUS_MIE]),
    .mie_meie    (bus.mie_q[MIE_MEI]),
    .mie_msie    (bus.mie_q[MIE_MSI]),
    .mie_mtie    (bus.mie_q[MIE_MTI]),
    .irq_take    (irq_take),
    .irq_code    (irq_code)
  );

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r                                = ms;
    r[MSTATUS_MPIE]                  = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]                   = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r                                = ms;
    r[MSTATUS_MIE]                   = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE]                  = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectored offset applies only to interrupts; exceptions always use the base.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                  input logic            irq,
                                                  input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    if (tvec == '0)
      return RESET_MTVEC;
    else if (irq && tvec[1:0] == 2'b01)
      return base + XLEN'({code, 2'b00});
    else
      return base;
  endfunction

  // Gated with rst so that outputs read all-zero for the whole reset window,
  // even while the commit inputs are still toggling.
  assign accept = (state == S_IDLE) && !rst && bus.commit_valid &&
                  (bus.exc_valid || bus.mret_valid || irq_take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      is_mret_r <= 1'b0;
      is_irq_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_mret_r <= !bus.exc_valid && bus.mret_valid;
        is_irq_r  <= !bus.exc_valid && !bus.mret_valid;
      end
    end
  end

  // Capture stage: trap payload latched at C0; never re-read from the bus.
  always_ff @(posedge clk) begin
    if (accept) begin
      epc_r  <= bus.commit_pc;
      code_r <= bus.exc_valid ? bus.exc_code : irq_code;
      tval_r <= bus.exc_valid ? bus.exc_tval : '0;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.csr_we         = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.flush          = 1'b0;
    bus.stall          = 1'b0;
    bus.busy           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          bus.flush = 1'b1;
          bus.stall = 1'b1;
          bus.busy  = 1'b1;
          state_nxt = (!bus.exc_valid && bus.mret_valid) ? S_M_MSTATUS : S_W_MEPC;
        end
      end
      S_W_MEPC: begin
        bus.stall     = 1'b1;
        bus.busy      = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MEPC;
        bus.csr_wdata = epc_r;
        state_nxt     = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        bus.stall     = 1'b1;
        bus.busy      = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MCAUSE;
        bus.csr_wdata = {is_irq_r, {(XLEN-5){1'b0}}, code_r};
        state_nxt     = S_W_MTVAL;
      end
      S_W_MTVAL: begin
        bus.stall     = 1'b1;
        bus.busy      = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MTVAL;
        bus.csr_wdata = tval_r;
        state_nxt     = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        bus.stall     = 1'b1;
        bus.busy      = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = trap_mstatus(bus.mstatus_q);
        state_nxt     = S_REDIRECT;
      end
      S_M_MSTATUS: begin
        bus.stall     = 1'b1;
        bus.busy      = 1'b1;
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MSTATUS;
        bus.csr_wdata = mret_mstatus(bus.mstatus_q);
        state_nxt     = S_REDIRECT;
      end
      S_REDIRECT: begin
        bus.stall          = 1'b1;
        bus.busy           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = is_mret_r ? (bus.mepc_q & ~XLEN'(3))
                                       : trap_target(bus.mtvec_q, is_irq_r, code_r);
        state_nxt          = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_seq.sv
// Testbench for trap_seq.
// Stimulus:
//   - Directed scenarios, followed by randomized events.
//   - While the sequencer is busy, the event inputs carry random garbage.
// Checking:
//   - Every cycle's outputs are compared against a per-event list of
//     expected cycles.
//   - That list is built from the architectural trap/MRET rules.
module tb_trap_seq;

  localparam logic [31:0] RST_VEC = 32'h0000_1000;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        flush, stall, busy, rv;
    logic [31:0] rpc;
  } exp_t;

  logic clk, rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  logic        s_cv, s_exc, s_mret, s_meip, s_msip, s_mtip;
  logic [3:0]  s_code;
  logic [31:0] s_pc, s_tval, s_mstatus, s_mie, s_mtvec, s_mepc;

  trap_seq_if #(.XLEN(32)) bus ();

  trap_seq #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic we, logic [11:0] addr, logic [31:0] data,
                              logic fl, logic st, logic bz, logic rv, logic [31:0] rpc);
    exp_t e;
    e.we = we; e.addr = addr; e.data = data; e.flush = fl;
    e.stall = st; e.busy = bz; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c%0d: observed %h expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic check_cycle(input exp_t e, input int k);
    chk("csr_we", k, 32'(bus.csr_we), 32'(e.we));
    chk("csr_waddr", k, 32'(bus.csr_waddr), 32'(e.addr));
    chk("csr_wdata", k, bus.csr_wdata, e.data);
    chk("flush", k, 32'(bus.flush), 32'(e.flush));
    chk("stall", k, 32'(bus.stall), 32'(e.stall));
    chk("busy", k, 32'(bus.busy), 32'(e.busy));
    chk("redirect_valid", k, 32'(bus.redirect_valid), 32'(e.rv));
    chk("redirect_pc", k, bus.redirect_pc, e.rpc);
  endtask

  task automatic clr();
    s_cv = 0; s_exc = 0; s_mret = 0; s_meip = 0; s_msip = 0; s_mtip = 0;
    s_code = 0; s_pc = 0; s_tval = 0; s_mstatus = 0; s_mie = 0; s_mtvec = 0; s_mepc = 0;
  endtask

  task automatic apply();
    bus.commit_valid = s_cv;  bus.commit_pc = s_pc;   bus.exc_valid = s_exc;
    bus.exc_code = s_code;    bus.exc_tval = s_tval;  bus.mret_valid = s_mret;
    bus.irq_meip = s_meip;    bus.irq_msip = s_msip;  bus.irq_mtip = s_mtip;
    bus.mstatus_q = s_mstatus; bus.mie_q = s_mie;     bus.mtvec_q = s_mtvec;
    bus.mepc_q = s_mepc;
  endtask

  // Event lines are don't-care while busy; CSR read values stay put.
  task automatic garble();
    bus.commit_valid = 1'($urandom); bus.exc_valid = 1'($urandom);
    bus.mret_valid = 1'($urandom);   bus.exc_code = 4'($urandom);
    bus.commit_pc = $urandom;        bus.exc_tval = $urandom;
    bus.irq_meip = 1'($urandom); bus.irq_msip = 1'($urandom); bus.irq_mtip = 1'($urandom);
  endtask

  // Reference model: from the stimulus variables, list what each cycle of
  // the resulting event must look like.
  task automatic build();
    logic lines[16];
    int codes[3] = '{11, 3, 7};
    int irq = -1;
    int kind;  // 0 none, 1 exception, 2 mret, 3 interrupt
    logic [31:0] cause, tval, ms, tgt;
    q.delete();
    foreach (lines[i]) lines[i] = 1'b0;
    lines[11] = s_meip; lines[3] = s_msip; lines[7] = s_mtip;
    if (s_mstatus[3])
      foreach (codes[i])
        if (irq < 0 && lines[codes[i]] && s_mie[codes[i]]) irq = codes[i];
    if (!s_cv)        kind = 0;
    else if (s_exc)   kind = 1;
    else if (s_mret)  kind = 2;
    else if (irq >= 0) kind = 3;
    else              kind = 0;
    if (kind == 0) begin
      q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    end else if (kind == 2) begin
      ms = (s_mstatus & ~32'h1888) | 32'h1880 | ((s_mstatus & 32'h80) >> 4);
      q.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
      q.push_back(mk(1, 12'h300, ms, 0, 1, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 1, 1, 1, s_mepc - (s_mepc % 4)));
    end else begin
      cause = (kind == 1) ? 32'(s_code) : (32'h8000_0000 + 32'(irq));
      tval  = (kind == 1) ? s_tval : 32'h0;
      ms    = (s_mstatus & ~32'h1888) | 32'h1800 | ((s_mstatus & 32'h8) << 4);
      if (s_mtvec == 0) tgt = RST_VEC;
      else begin
        tgt = s_mtvec - (s_mtvec % 4);
        if (kind == 3 && (s_mtvec % 4) == 1) tgt = tgt + 32'(4 * irq);
      end
      q.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
      q.push_back(mk(1, 12'h341, s_pc, 0, 1, 1, 0, 0));
      q.push_back(mk(1, 12'h342, cause, 0, 1, 1, 0, 0));
      q.push_back(mk(1, 12'h343, tval, 0, 1, 1, 0, 0));
      q.push_back(mk(1, 12'h300, ms, 0, 1, 1, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 1, 1, 1, tgt));
    end
  endtask

  task automatic run_event();
    @(negedge clk);
    apply();
    build();
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) begin
        @(negedge clk);
        garble();
      end
      #1;
      check_cycle(q[k], k);
    end
  endtask

  task automatic rand_stim();
    int r;
    s_cv = ($urandom_range(0, 7) != 0);
    s_exc = ($urandom_range(0, 3) == 0);
    s_mret = ($urandom_range(0, 3) == 0);
    s_code = 4'($urandom);
    s_pc = $urandom; s_tval = $urandom; s_mepc = $urandom;
    s_meip = 1'($urandom); s_msip = 1'($urandom); s_mtip = 1'($urandom);
    s_mie = $urandom; s_mstatus = $urandom;
    r = $urandom_range(0, 3);
    if (r == 0)      s_mtvec = 0;
    else if (r == 1) s_mtvec = ($urandom & ~32'h3) | 32'h1;
    else             s_mtvec = $urandom;
  endtask

  initial begin
    clr();
    apply();
    rst = 1'b1;
    #1;
    check_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Illegal instruction
    clr(); s_cv = 1; s_exc = 1; s_code = 2; s_pc = 32'h100; s_tval = 32'hDEAD;
    s_mtvec = 32'h200; s_mstatus = 32'h8;
    run_event();

    // Vectored timer interrupt
    clr(); s_cv = 1; s_mtip = 1; s_mie = 32'h80; s_mstatus = 32'h8; s_mtvec = 32'h201; s_pc = 32'h44;
    run_event();

    // MRET
    clr(); s_cv = 1; s_mret = 1; s_mstatus = 32'h1880; s_mepc = 32'h106;
    run_event();

    // MEI + MTI with an exception: the exception wins
    clr(); s_cv = 1; s_exc = 1; s_code = 11; s_meip = 1; s_mtip = 1; s_mie = 32'h880;
    s_mstatus = 32'h8; s_mtvec = 32'h401; s_pc = 32'h300;
    run_event();
    s_exc = 0; s_mstatus = 32'h0;
    run_event();
    s_mstatus = 32'h8;
    run_event();

    // Masked software interrupt, then unmasked
    clr(); s_cv = 1; s_msip = 1; s_mie = 32'h8; s_mtvec = 32'h0; s_pc = 32'h80;
    repeat (10) run_event();
    s_mstatus = 32'h8;
    run_event();

    // Reset in the middle of a trap, then a full trap
    clr(); s_cv = 1; s_exc = 1; s_code = 5; s_pc = 32'h500; s_tval = 32'h77;
    s_mtvec = 32'h600; s_mstatus = 32'h8;
    @(negedge clk);
    apply();
    build();
    #1;
    check_cycle(q[0], 0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      garble();
      #1;
      check_cycle(q[k], k);
    end
    rst = 1'b1;
    #1;
    check_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 90);
    @(negedge clk);
    bus.commit_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0), 91);
    run_event();

    // Randomized events, back to back
    for (int n = 0; n < 80; n++) begin
      rand_stim();
      run_event();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
